// File: rtl/wam_pkg.sv
// Shared whack-a-mole definitions: hole count, score width, hit FSM encoding
// and a saturating counter helper used by the hit detector and light driver.
package wam_pkg;

    localparam int NUM_HOLES = 9;
    localparam int SCORE_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } wam_state_e;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : SCORE_W'(v + SCORE_W'(1));
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Single-button debouncer: the output level follows the input only after the
// input has differed from it for CYCLES consecutive clocks (CYCLES >= 1).
module button_debouncer #(
    parameter logic [19:0] CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [19:0] cnt_q, cnt_d;
    logic        level_q, level_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (din != level_q) begin
            // Flip on the CYCLES-th consecutive clock of disagreement.
            if (({1'b0, cnt_q} + 21'd1) >= {1'b0, CYCLES}) begin
                level_d = din;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign dout = level_q;

endmodule

// File: rtl/hit_detector.sv
// Whack-a-mole hit detector: synchronizes buttons, edge-detects presses and
// scores them against the lit hole. Define HIT_DEBOUNCE_EN to add debouncing.
module hit_detector
    import wam_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] lights,
    input  logic [NUM_HOLES-1:0] buttons,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   misses,
    output logic                 hit,
    output logic                 miss,
    output logic                 wrong
);

    logic [NUM_HOLES-1:0] sync1_q, sync2_q;
    logic [NUM_HOLES-1:0] filt;
    logic [NUM_HOLES-1:0] prev_q;
    logic [NUM_HOLES-1:0] block_q, block_d;
    logic [NUM_HOLES-1:0] press;
    logic [1:0]           settle_q;
    logic                 ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= buttons;
            sync2_q <= sync1_q;
        end
    end

`ifdef HIT_DEBOUNCE_EN
    for (genvar i = 0; i < NUM_HOLES; i++) begin : g_deb
        button_debouncer #(
            .CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .din  (sync2_q[i]),
            .dout (filt[i])
        );
    end
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
    assign filt = sync2_q;
`endif

    // A button held through reset stays blocked until the synchronizer has
    // refilled and both the raw and filtered levels have been seen low.
    assign ready   = settle_q[1];
    assign block_d = block_q & ~({NUM_HOLES{ready}} & ~sync2_q & ~filt);
    assign press   = filt & ~prev_q & ~block_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q   <= '0;
            block_q  <= '1;
            settle_q <= '0;
        end else begin
            prev_q   <= filt;
            block_q  <= block_d;
            settle_q <= {settle_q[0], 1'b1};
        end
    end

    wam_state_e         state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] misses_q, misses_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               wrong_q, wrong_d;

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        misses_d = misses_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        wrong_d  = 1'b0;
        if (!start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lights != '0) state_d = ARMED;
                end
                ARMED: begin
                    // An expired light wins over any press in the same cycle.
                    if (lights == '0) begin
                        miss_d   = 1'b1;
                        misses_d = sat_inc(misses_q);
                        state_d  = IDLE;
                    end else if ((press & lights) != '0) begin
                        hit_d   = 1'b1;
                        score_d = sat_inc(score_q);
                        state_d = DONE;
                    end else if (press != '0) begin
                        wrong_d = 1'b1;
                    end
                end
                DONE: begin
                    if (lights == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            score_q  <= '0;
            misses_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            wrong_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            wrong_q  <= wrong_d;
        end
    end

    assign score  = score_q;
    assign misses = misses_q;
    assign hit    = hit_q;
    assign miss   = miss_q;
    assign wrong  = wrong_q;

endmodule

// File: doc/hit_detector.md
HIT_DETECTOR -- requirements
Module: hit_detector

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20'd500000, the number of clocks a synchronized button must hold steady before it is accepted (used only with HIT_DEBOUNCE_EN).
REQ-002 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  game running; low forces idle.
REQ-005 SHALL have port lights  input  9  lit-hole vector from the light driver, zero or one-hot.
REQ-006 SHALL have port buttons  input  9  raw asynchronous player buttons, active-high, bit i = hole i.
REQ-007 SHALL have port score  output  8  count of hits, registered.
REQ-008 SHALL have port misses  output  8  count of lit holes that expired without a hit, registered.
REQ-009 SHALL have port hit  output  1  one-cycle pulse on a correct press.
REQ-010 SHALL have port miss  output  1  one-cycle pulse on an expired light.
REQ-011 SHALL have port wrong  output  1  one-cycle pulse on a press of an unlit hole while armed.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer, then rising-edge detect into press[8:0]; pin-to-press latency 3 clocks without debounce.
REQ-013 SHALL implement FSM states IDLE, ARMED, DONE.
REQ-014 IDLE -> ARMED when start=1 and lights!=0; presses in IDLE are ignored.
REQ-015 In ARMED, if lights!=0 and (press & lights)!=0: hit=1, score+1, next DONE.
REQ-016 In ARMED, if lights!=0, (press & lights)==0 and press!=0: wrong=1, score unchanged, stay ARMED.
REQ-017 Correct and wrong presses in the same cycle SHALL count as a hit only.
REQ-018 In ARMED, if lights==0: miss=1, misses+1, next IDLE; any press in that cycle is ignored.
REQ-019 DONE -> IDLE when lights==0; presses in DONE are ignored.
REQ-020 score and misses SHALL saturate at 8'd255, never wrap; the pulse still fires at saturation.
REQ-021 start=0 SHALL force IDLE on the next edge, suppress all pulses, and hold score and misses.
REQ-022 hit, miss and wrong SHALL be mutually exclusive and last exactly one clock.
REQ-023 Counter and pulse updates SHALL occur on the same edge as the FSM transition that causes them.

Reset
REQ-024 reset=0 SHALL asynchronously force IDLE, score=0, misses=0, hit=miss=wrong=0, clear synchronizer, edge and debounce state.
REQ-025 Reset mid-ARMED SHALL produce no miss pulse; after release a still-lit hole re-arms via IDLE.
REQ-026 A button held across reset release SHALL NOT generate a press until it is released and pressed again.

Configuration
REQ-027 Macro HIT_DEBOUNCE_EN defined: each synchronized button SHALL be stable for DEBOUNCE_CYCLES clocks before its filtered level changes; press edge-detects the filtered level; latency 3+DEBOUNCE_CYCLES.
REQ-028 Macro HIT_DEBOUNCE_EN undefined: no debounce logic SHALL be built; DEBOUNCE_CYCLES is unused; latency per REQ-012.

Structure
REQ-029 Shared package wam_pkg SHALL hold NUM_HOLES=9, SCORE_W=8, and the IDLE/ARMED/DONE state encoding, for use by this block and the light driver.
REQ-030 Debouncing SHALL be a sub-module button_debouncer, instantiated once per hole under HIT_DEBOUNCE_EN.

Verification
REQ-031 start=1, lights=9'h010, pulse buttons[4] -> hit pulse 3 clocks later (undebounced), score=1, FSM DONE; lights=0 -> IDLE, misses=0.
REQ-032 lights=9'h001, press buttons[5] -> wrong pulse, score=0; then lights=0 with no press -> miss pulse, misses=1.
REQ-033 lights=9'h004, buttons[2] and buttons[7] rise in the same cycle -> hit only, no wrong pulse, score+1.
REQ-034 Preload 255 hits, then one more correct press -> hit pulse, score stays 255.
REQ-035 Assert reset while ARMED with buttons[3] held -> all outputs 0 immediately, no miss; after release, held button gives no hit until re-pressed.
REQ-036 With HIT_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: a 2-clock glitch on buttons[0] with lights=9'h001 -> no hit; a 10-clock press -> exactly one hit, 7 clocks after the rising edge.
